// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the cnt button controller.
// Debounce state enum, default timing constants, counter width helper.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } db_state_e;

  localparam int DEF_DEBOUNCE = 500000;
  localparam int DEF_DELAY    = 25000000;
  localparam int DEF_PERIOD   = 10000000;

  // Bits needed to hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce.sv
// One button: 2-flop synchronizer, debounce FSM and stability counter.
// Ports: clk, rst (sync, active-low), btn (raw) -> press (1-cycle), held.
module debounce
  import cnt_ctrl_pkg::*;
#(
  parameter int CYCLES = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press,
  output logic held
);

  localparam int W = cnt_w(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic s1;
  logic s2;
  db_state_e st;
  db_state_e st_nxt;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      st  <= IDLE;
      cnt <= '0;
    end else begin
      s1  <= btn;
      s2  <= s1;
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    unique case (st)
      IDLE: begin
        if (s2) begin
          st_nxt  = ARM_PRESS;
          cnt_nxt = '0;
        end
      end
      ARM_PRESS: begin
        if (!s2)
          st_nxt = IDLE;
        else if (cnt == LAST)
          st_nxt = PRESSED;
        else
          cnt_nxt = cnt + 1'b1;
      end
      PRESSED: begin
        if (!s2) begin
          st_nxt  = ARM_RELEASE;
          cnt_nxt = '0;
        end
      end
      ARM_RELEASE: begin
        if (s2)
          st_nxt = PRESSED;
        else if (cnt == LAST)
          st_nxt = IDLE;
        else
          cnt_nxt = cnt + 1'b1;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Mealy strobe: fires in the last arming cycle so the
  // registered output lands one cycle later.
  always_comb begin
    press = (st == ARM_PRESS) && s2 && (cnt == LAST);
    held  = (st == PRESSED);
  end

endmodule

// File: rtl/cnt_ctrl.sv
// Pushbutton/switch front end for the cnt up/down counter.
// Ports: clk, rst (sync, active-low), btn_up/btn_down/btn_load, sw[3:0]
// in; en, up, load, count_in[3:0] out (all registered).
module cnt_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int REPEAT_DELAY    = DEF_DELAY,
  parameter int REPEAT_PERIOD   = DEF_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic [3:0] sw,
  output logic       en,
  output logic       up,
  output logic       load,
  output logic [3:0] count_in
);

  localparam int RMAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_w(RMAX);
  localparam logic [RW-1:0] DLY_M1 =
    RW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RW-1:0] PER_M1 =
    RW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic press_up;
  logic press_dn;
  logic press_ld;
  logic held_up;
  logic held_dn;
  logic ld_held_unused;

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .press (press_up),
    .held  (held_up)
  );

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .press (press_dn),
    .held  (held_dn)
  );

  debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_ld (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_load),
    .press (press_ld),
    .held  (ld_held_unused)
  );

  logic [3:0] sw_s1;
  logic [3:0] sw_s2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      count_in <= '0;
    end else begin
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      count_in <= sw_s2;
    end
  end

  // Auto-repeat runs only while exactly one direction is held.
  logic          rep_act;
  logic          rep;
  logic          first;
  logic [RW-1:0] rcnt;

  assign rep_act = (REPEAT_DELAY != 0) && (held_up ^ held_dn);
  assign rep     = rep_act &&
                   (rcnt == (first ? DLY_M1 : PER_M1));

  always_ff @(posedge clk) begin
    if (!rst || !rep_act) begin
      rcnt  <= '0;
      first <= 1'b1;
    end else if (rep) begin
      rcnt  <= '0;
      first <= 1'b0;
    end else begin
      rcnt  <= rcnt + 1'b1;
    end
  end

  logic step_up;
  logic step_dn;

  assign step_up = press_up | (rep & held_up);
  assign step_dn = press_dn | (rep & held_dn);

  // Load wins over steps; opposing steps cancel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en   <= 1'b0;
      up   <= 1'b0;
      load <= 1'b0;
    end else begin
      en   <= 1'b0;
      load <= 1'b0;
      if (press_ld) begin
        load <= 1'b1;
      end else if (step_up && !step_dn) begin
        en <= 1'b1;
        up <= 1'b1;
      end else if (step_dn && !step_up) begin
        en <= 1'b1;
        up <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnt_ctrl.sv
// Directed self-checking bench for cnt_ctrl.
// Offsets count clock edges after an input change.
module tb_cnt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up;
  logic       btn_down;
  logic       btn_load;
  logic [3:0] sw;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] count_in;

  cnt_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .sw       (sw),
    .en       (en),
    .up       (up),
    .load     (load),
    .count_in (count_in)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   fails  = 0;
  int   t      = 0;
  int   both_bad = 0;
  int   up_bad   = 0;
  logic up_prev  = 1'b0;
  int   en_q[$];
  int   up_q[$];
  int   ld_q[$];
  int   cin_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    t = 0;
    en_q.delete();
    up_q.delete();
    ld_q.delete();
    cin_q.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t++;
      if (en === 1'b1) begin
        en_q.push_back(t);
        up_q.push_back(int'(up));
      end
      if (load === 1'b1) begin
        ld_q.push_back(t);
        cin_q.push_back(int'(count_in));
      end
      if (en === 1'b1 && load === 1'b1) both_bad++;
      if (rst && up !== up_prev && en !== 1'b1) up_bad++;
      up_prev = up;
    end
  endtask

  task automatic settle();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    btn_load = 1'b0;
    run(20);
    clear();
  endtask

  task automatic chk_steps(input string tag, input int n,
                           input int exp[6], input int exp_up);
    chk({tag, "_n"}, en_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < en_q.size()) begin
        chk($sformatf("%s_pos%0d", tag, i), en_q[i], exp[i]);
        chk($sformatf("%s_up%0d", tag, i), up_q[i], exp_up);
      end
    end
  endtask

  task automatic chk_load(input string tag, input int exp_cin);
    chk({tag, "_n"}, ld_q.size(), 1);
    if (ld_q.size() > 0) begin
      chk({tag, "_pos"}, ld_q[0], 7);
      chk({tag, "_cin"}, cin_q[0], exp_cin);
    end
    chk({tag, "_en"}, en_q.size(), 0);
  endtask

  initial begin
    rst      = 1'b0;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    btn_load = 1'b1;
    sw       = 4'h5;
    run(3);
    chk("rst_en", int'(en), 0);
    chk("rst_load", int'(load), 0);
    chk("rst_up", int'(up), 0);
    chk("rst_cin", int'(count_in), 0);

    // Buttons held across reset release: full debounce again.
    rst = 1'b1;
    clear();
    run(14);
    chk_load("rel", 5);
    settle();

    btn_up = 1'b1;
    run(10);
    btn_up = 1'b0;
    run(25);
    chk_steps("clean", 1, '{7, 0, 0, 0, 0, 0}, 1);
    chk("clean_ld", ld_q.size(), 0);
    settle();

    for (int i = 0; i < 5; i++) begin
      btn_down = 1'b1;
      run(2);
      btn_down = 1'b0;
      run(2);
    end
    chk("bounce_none", en_q.size(), 0);
    btn_down = 1'b1;
    run(10);
    btn_down = 1'b0;
    run(25);
    chk_steps("bounce", 1, '{27, 0, 0, 0, 0, 0}, 0);
    settle();

    sw = 4'hA;
    btn_load = 1'b1;
    run(10);
    btn_load = 1'b0;
    run(25);
    chk_load("load", 10);
    settle();

    btn_load = 1'b1;
    btn_up   = 1'b1;
    run(10);
    btn_load = 1'b0;
    btn_up   = 1'b0;
    run(25);
    chk_load("ld_up", 10);
    settle();

    btn_up = 1'b1;
    run(60);
    btn_up = 1'b0;
    run(30);
    chk_steps("rep", 6, '{7, 27, 35, 43, 51, 59}, 1);
    settle();

    btn_up   = 1'b1;
    btn_down = 1'b1;
    run(40);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    run(25);
    chk("both_en", en_q.size(), 0);
    settle();

    btn_up = 1'b1;
    run(4);
    rst    = 1'b0;
    btn_up = 1'b0;
    run(1);
    rst = 1'b1;
    run(20);
    chk("rst_abort", en_q.size(), 0);
    settle();

    btn_up = 1'b1;
    run(4);
    rst = 1'b0;
    run(1);
    rst = 1'b1;
    run(10);
    btn_up = 1'b0;
    run(25);
    chk_steps("rst_held", 1, '{12, 0, 0, 0, 0, 0}, 1);
    settle();

    chk("en_and_load", both_bad, 0);
    chk("up_glitch", up_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
